ex_div: RTL and testbench
=========================

# ex_div

Multi-cycle RV32M divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It takes the operands, funct3 and destination register of a DIV/DIVU/REM/REMU instruction held in ID/EX. It computes the result with a radix-2 restoring algorithm, one quotient bit per cycle. While busy it requests a pipeline stall, then presents the result for one cycle so the execute stage can forward it to EX/MEM.

## Interface
Parameters:
- XLEN, 32: operand and result width.
- CNT_W, 6: iteration counter width; must hold XLEN.

Ports (name, direction, width, meaning):
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_i, input, 1: reset, asynchronous, active-low.
- start_i, input, 1: execute stage holds a divide instruction; sampled only in IDLE.
- op_i, input, 2: funct3[1:0]; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i, input, XLEN: rs1 value (ID/EX op1).
- divisor_i, input, XLEN: rs2 value (ID/EX op2).
- rd_i, input, 5: destination register.
- flush_i, input, 1: OR of the jump and interrupt flushes; aborts the operation.
- result_o, output, XLEN: quotient or remainder; valid while ready_o=1.
- rd_o, output, 5: latched destination register.
- ready_o, output, 1: one-cycle pulse, result valid.
- busy_o, output, 1: high in CALC.
- stall_req_o, output, 1: stall request to the pipeline controller.

## Operation
- State machine: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and flush_i=0 latches the operands, op and rd.
  - divisor_i==0 goes to DONE with the fast-path result:
    - quotient = all ones;
    - remainder = dividend_i unmodified (signed and unsigned).
  - Otherwise goes to CALC with count=0.
- Operand preparation at latch:
  - Signed ops (op_i[0]=0) convert each operand to its magnitude.
  - neg_q = sign(dividend) XOR sign(divisor).
  - neg_r = sign(dividend).
  - Unsigned ops clear both flags.
- CALC:
  - Each cycle shifts the {rem, quo} pair left by 1 and trial-subtracts the divisor from the partial remainder (XLEN+1 bit subtract).
  - Non-negative difference: keep it and set quotient LSB=1; else quotient LSB=0.
  - count increments; after the iteration with count==XLEN-1, go to DONE.
- DONE:
  - result_o = op[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo), all modulo 2^XLEN.
  - ready_o=1 for exactly this cycle, then unconditionally IDLE.
- Signed overflow (0x80000000 / -1) takes the normal path:
  - magnitude 2^31 / 1 yields quotient 0x80000000, remainder 0.
  - This matches the RISC-V spec; no special case.
- stall_req_o = (IDLE and start_i and not flush_i) or CALC; low in DONE so the pipeline advances and captures result_o.
- start_i outside IDLE is ignored; operands are not re-sampled during CALC or DONE.
- flush_i in CALC: go to IDLE next edge, no ready_o pulse, stall_req_o drops combinationally in that cycle.
- flush_i in DONE: ready_o still pulses; the consumer discards it.
- flush_i with start_i in IDLE: start ignored.

## Timing
- Reset (rst_i=0, asynchronous):
  - state=IDLE, count=0.
  - result_o=0, rd_o=0, ready_o=0, busy_o=0, stall_req_o=0.
- Release is synchronous to the next rising edge.
- Normal latency: start seen in IDLE at cycle 0; CALC in cycles 1..XLEN; DONE (ready_o=1) in cycle XLEN+1, i.e. 33; IDLE in cycle 34.
- Divide-by-zero latency: DONE in cycle 1, IDLE in cycle 2.
- stall_req_o high from cycle 0 through cycle XLEN inclusive.
- A new start_i is accepted at the earliest in the cycle after DONE.
- result_o and rd_o hold their last value outside DONE; only ready_o qualifies them.
- Reset asserted mid-CALC: immediate return to reset values, no ready_o pulse.

## Test plan
- DIV 100 / 7 -> result 14 with ready_o in cycle 33; stall_req_o high in cycles 0-32 and low in cycle 33; rd_o equals rd_i.
- REM -100 (0xFFFFFF9C) / 7 -> 0xFFFFFFFE; DIVU 0xFFFFFF9C / 7 -> 0x24924916; REMU same operands -> 0x2.
- DIVU 1234 / 0 -> 0xFFFFFFFF with ready_o in cycle 1; REM -5 / 0 -> 0xFFFFFFFB.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both in cycle 33.
- flush_i in CALC cycle 10 -> IDLE next edge, no ready_o pulse, stall_req_o low; a new DIVU 9 / 3 started next cycle -> 3 in cycle 33 of that operation.
- rst_i low in CALC cycle 5 -> all outputs 0 immediately; after release, DIV 7 / -2 -> 0xFFFFFFFD.

Source files
------------

// File: rtl/ex_div.sv
// ex_div: multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU), radix-2 restoring.
// Ports: clk_i/rst_i; start_i, op_i, dividend_i, divisor_i, rd_i, flush_i in;
//        result_o, rd_o, ready_o (1-cycle result pulse), busy_o, stall_req_o out.
module ex_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            ready_o,
    output logic            busy_o,
    output logic            stall_req_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   dvs;
    logic              neg_q;
    logic              neg_r;
    logic              is_rem;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   res_hold;

    logic              accept;
    logic              last_iter;
    logic              is_signed;
    logic              sgn_a;
    logic              sgn_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   res_comb;

    assign accept    = (state == IDLE) && start_i && !flush_i;
    assign last_iter = (count == CNT_W'(XLEN - 1));

    // Operand magnitudes for signed ops; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    assign is_signed = !op_i[0];
    assign sgn_a     = is_signed && dividend_i[XLEN-1];
    assign sgn_b     = is_signed && divisor_i[XLEN-1];
    assign mag_a     = sgn_a ? (~dividend_i + 1'b1) : dividend_i;
    assign mag_b     = sgn_b ? (~divisor_i + 1'b1) : divisor_i;

    // One restoring step: shift next dividend bit into the partial remainder
    // and trial-subtract with one guard bit.
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_comb begin
        res_comb = '0;
        if (is_rem) begin
            res_comb = neg_r ? (~rem + 1'b1) : rem;
        end else begin
            res_comb = neg_q ? (~quo + 1'b1) : quo;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (divisor_i == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_rem   <= 1'b0;
            rd_q     <= '0;
            res_hold <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                is_rem <= op_i[1];
                rd_q   <= rd_i;
                count  <= '0;
                if (divisor_i == '0) begin
                    // Fast path: quotient all ones, remainder is the raw
                    // dividend regardless of signedness.
                    rem   <= dividend_i;
                    quo   <= '1;
                    dvs   <= '0;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else begin
                    // quo starts as the dividend magnitude and is shifted out
                    // MSB-first while quotient bits fill in at the LSB.
                    rem   <= '0;
                    quo   <= mag_a;
                    dvs   <= mag_b;
                    neg_q <= sgn_a ^ sgn_b;
                    neg_r <= sgn_a;
                end
            end else if (state == CALC) begin
                count <= count + 1'b1;
                if (!diff[XLEN]) begin
                    rem <= diff[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b1};
                end else begin
                    rem <= shifted[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b0};
                end
            end else if (state == DONE) begin
                res_hold <= res_comb;
            end
        end
    end

    assign result_o    = (state == DONE) ? res_comb : res_hold;
    assign rd_o        = rd_q;
    assign ready_o     = (state == DONE);
    assign busy_o      = (state == CALC);
    assign stall_req_o = accept || ((state == CALC) && !flush_i);

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed and random checks of ex_div against an arithmetic
// reference model of the RV32M divide rules.
module tb_ex_div;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        ready_o;
    logic        busy_o;
    logic        stall_req_o;

    int vectors = 0;
    int miscompares = 0;

    ex_div #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .op_i(op_i),
        .dividend_i(dividend_i),
        .divisor_i(divisor_i),
        .rd_i(rd_i),
        .flush_i(flush_i),
        .result_o(result_o),
        .rd_o(rd_o),
        .ready_o(ready_o),
        .busy_o(busy_o),
        .stall_req_o(stall_req_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Called at posedge+1 in an IDLE cycle; that cycle is cycle 0.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int lat;
        logic stall_ok;
        logic [31:0] exp;
        exp = model(op, a, b);
        start_i = 1'b1;
        op_i = op;
        dividend_i = a;
        divisor_i = b;
        rd_i = rd;
        #1;
        chk("stall_c0", {31'd0, stall_req_o}, 32'd1);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        dividend_i = $urandom;
        divisor_i = $urandom;
        rd_i = 5'(~rd);
        lat = 1;
        stall_ok = 1'b1;
        while (!ready_o && lat < 40) begin
            if (!stall_req_o || !busy_o) stall_ok = 1'b0;
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
        chk("stall_calc", {31'd0, stall_ok}, 32'd1);
        chk("result", result_o, exp);
        chk("rd", {27'd0, rd_o}, {27'd0, rd});
        chk("stall_done", {31'd0, stall_req_o}, 32'd0);
        @(posedge clk_i);
        #1;
        chk("ready_off", {30'd0, ready_o, busy_o}, 32'd0);
        chk("result_hold", result_o, exp);
    endtask

    initial begin
        rst_i = 1'b0;
        start_i = 1'b0;
        op_i = 2'd0;
        dividend_i = '0;
        divisor_i = '0;
        rd_i = '0;
        flush_i = 1'b0;
        #2;
        chk("rst_result", result_o, 32'd0);
        chk("rst_ctl", {24'd0, rd_o, ready_o, busy_o, stall_req_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        do_op(2'b00, 32'd100, 32'd7, 5'd11);
        do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd3);
        do_op(2'b01, 32'hFFFF_FF9C, 32'd7, 5'd4);
        do_op(2'b11, 32'hFFFF_FF9C, 32'd7, 5'd5);
        do_op(2'b01, 32'd1234, 32'd0, 5'd6);
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd7);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);

        // Flush in CALC cycle 10.
        start_i = 1'b1;
        op_i = 2'b01;
        dividend_i = 32'd1000;
        divisor_i = 32'd7;
        rd_i = 5'd12;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk_i);
            #1;
        end
        chk("pre_flush_busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall_req_o}, 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        chk("flush_idle", {29'd0, ready_o, busy_o, stall_req_o}, 32'd0);
        do_op(2'b01, 32'd9, 32'd3, 5'd13);

        // Reset in CALC cycle 5.
        start_i = 1'b1;
        op_i = 2'b00;
        dividend_i = 32'd500;
        divisor_i = 32'd3;
        rd_i = 5'd14;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int c = 1; c < 5; c++) begin
            @(posedge clk_i);
            #1;
        end
        rst_i = 1'b0;
        #1;
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_ctl", {24'd0, rd_o, ready_o, busy_o, stall_req_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        do_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd15);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = b >> $urandom_range(1, 31);
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op(op, a, b, 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
